div: RTL and testbench

- Sequential restoring divider. It is the inverse companion of the team's shift-add multiplier `mult`.
- Takes a 32-bit dividend and a 16-bit divisor. Produces a 32-bit quotient and a 16-bit remainder, one quotient bit per clock.
- Uses the same init/done handshake as `mult`, including a stretched done pulse, so the same slow peripheral-bus wrapper on the femtoRV SoC can poll it.

---
 rtl/div_if.sv | 37 +++
 rtl/div.sv | 144 ++++++++++++++
 tb/tb_div.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Handshake and data bundle for the sequential divider: init/done control plus operands and results.
// With DIV_ZERO_FLAG_EN defined the bundle also carries the divide-by-zero flag dz.
interface div_if;
    logic        init;
    logic        done;
`ifdef DIV_ZERO_FLAG_EN
    logic        dz;
`endif
    logic [31:0] quotient;
    logic [15:0] remainder;
    logic [31:0] op_A;
    logic [15:0] op_B;

    modport master (
        output init,
        output op_A,
        output op_B,
        input  done,
`ifdef DIV_ZERO_FLAG_EN
        input  dz,
`endif
        input  quotient,
        input  remainder
    );

    modport slave (
        input  init,
        input  op_A,
        input  op_B,
        output done,
`ifdef DIV_ZERO_FLAG_EN
        output dz,
`endif
        output quotient,
        output remainder
    );
endinterface

// File: rtl/div.sv
// Sequential restoring divider, 32-bit dividend by 16-bit divisor, one quotient bit per clock,
// with a stretched done pulse. Optional macro DIV_ZERO_FLAG_EN adds the dz output.
module div #(
    parameter int DONE_HOLD = 30
) (
    input  logic clk,
    input  logic reset,
    div_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_END  = 2'd3;

    localparam logic [7:0] HOLD_LAST = 8'(DONE_HOLD);
    localparam logic [5:0] ITER_LAST = 6'd31;

    logic [1:0]  state_q, state_d;
    logic [5:0]  iter_cnt_q, iter_cnt_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [31:0] wdiv_q, wdiv_d;
    logic [15:0] divisor_q, divisor_d;
    logic [16:0] prem_q, prem_d;
    logic [31:0] quotient_q, quotient_d;
    logic [15:0] remainder_q, remainder_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;

    logic [16:0] shifted;
    logic [16:0] trial;
    logic        div_zero;
    logic        prem_top_unused;

    // The partial remainder never exceeds the divisor, so its top bit stays zero between steps.
    assign prem_top_unused = prem_q[16];

    always_comb begin
        shifted     = {prem_q[15:0], wdiv_q[31]};
        trial       = shifted - {1'b0, divisor_q};
        div_zero    = (divisor_q == 16'd0);

        state_d     = state_q;
        iter_cnt_d  = iter_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        wdiv_d      = wdiv_q;
        divisor_d   = divisor_q;
        prem_d      = prem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = done_q;
        dz_d        = dz_q;

        case (state_q)
            S_IDLE: begin
                done_d = 1'b0;
                if (bus.init) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                wdiv_d     = bus.op_A;
                divisor_d  = bus.op_B;
                prem_d     = 17'd0;
                iter_cnt_d = 6'd0;
                hold_cnt_d = 8'd0;
                dz_d       = 1'b0;
                state_d    = (bus.op_B == 16'd0) ? S_END : S_ITER;
            end

            S_ITER: begin
                // Restore on borrow: keep the shifted value instead of the trial difference.
                prem_d     = trial[16] ? shifted : trial;
                wdiv_d     = {wdiv_q[30:0], ~trial[16]};
                iter_cnt_d = iter_cnt_q + 6'd1;
                if (iter_cnt_q == ITER_LAST) begin
                    state_d = S_END;
                end
            end

            S_END: begin
                if (!done_q) begin
                    done_d     = 1'b1;
                    hold_cnt_d = 8'd1;
                    if (div_zero) begin
                        quotient_d  = 32'hFFFF_FFFF;
                        remainder_d = wdiv_q[15:0];
                        dz_d        = 1'b1;
                    end else begin
                        quotient_d  = wdiv_q;
                        remainder_d = prem_q[15:0];
                        dz_d        = 1'b0;
                    end
                end else if (hold_cnt_q >= HOLD_LAST) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end

            default: begin
                done_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            iter_cnt_q  <= 6'd0;
            hold_cnt_q  <= 8'd0;
            wdiv_q      <= 32'd0;
            divisor_q   <= 16'd0;
            prem_q      <= 17'd0;
            quotient_q  <= 32'd0;
            remainder_q <= 16'd0;
            done_q      <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            iter_cnt_q  <= iter_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            wdiv_q      <= wdiv_d;
            divisor_q   <= divisor_d;
            prem_q      <= prem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dz_q        <= dz_d;
        end
    end

    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
`ifdef DIV_ZERO_FLAG_EN
    assign bus.dz        = dz_q;
`else
    logic dz_unused;
    assign dz_unused = dz_q;
`endif
endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: stimulus pushes hand-computed results, a negedge monitor pops and
// compares on each rising done, and also checks latency, window length and result retention.
module tb_div;
    localparam int HOLD = 30;

    typedef struct {
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        int          start;
        int          lat;
    } exp_t;

    logic clk;
    logic reset;
    div_if bus();

    div #(.DONE_HOLD(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pushed = 0;
    int          rises = 0;
    logic [31:0] last_q = 32'd0;
    logic [15:0] last_r = 16'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, well away from the active edge.
    initial begin
        logic done_prev;
        int   hold_cnt;
        exp_t e;
        done_prev = 1'b0;
        hold_cnt  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                done_prev = 1'b0;
                hold_cnt  = 0;
            end else begin
                if (bus.done && !done_prev) begin
                    rises++;
                    hold_cnt = 1;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got q=0x%08h r=0x%04h expected no result", bus.quotient, bus.remainder);
                    end else begin
                        e = sb.pop_front();
                        chk("quotient", bus.quotient, e.q);
                        chk("remainder", {16'd0, bus.remainder}, {16'd0, e.r});
                        chk("latency", 32'(cyc - e.start), 32'(e.lat));
`ifdef DIV_ZERO_FLAG_EN
                        chk("dz", {31'd0, bus.dz}, {31'd0, e.dz});
`endif
                        last_q = e.q;
                        last_r = e.r;
                        $display("result q=0x%08h r=0x%04h latency=%0d", bus.quotient, bus.remainder, cyc - e.start);
                    end
                end else if (bus.done) begin
                    hold_cnt++;
                end else if (done_prev) begin
                    chk("done_window", 32'(hold_cnt), 32'(HOLD));
                    chk("idle_keep_q", bus.quotient, last_q);
                    chk("idle_keep_r", {16'd0, bus.remainder}, {16'd0, last_r});
                end
                done_prev = bus.done;
            end
        end
    end

    task automatic push_exp(input logic [31:0] q, input logic [15:0] r, input logic dz,
                            input int start, input int lat);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz; e.start = start; e.lat = lat;
        sb.push_back(e);
        pushed++;
    endtask

    // Raises init for one cycle; returns on the falling edge just after the sampling edge.
    task automatic start_op(input logic [31:0] a, input logic [15:0] b, input logic [31:0] q,
                            input logic [15:0] r, input logic dz, input int lat, input bit push);
        @(negedge clk);
        bus.op_A = a;
        bus.op_B = b;
        bus.init = 1'b1;
        if (push) push_exp(q, r, dz, cyc + 1, lat);
        $display("issue op_A=0x%08h op_B=0x%04h", a, b);
        @(negedge clk);
        bus.init = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || bus.done) && n < limit);
        if (sb.size() != 0 || bus.done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending results expected 0 after %0d cycles", name, sb.size(), limit);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [15:0] b, input logic [31:0] q,
                          input logic [15:0] r, input logic dz, input int lat);
        start_op(a, b, q, r, dz, lat, 1'b1);
        wait_idle("op", 200);
    endtask

    initial begin
        int s;
        reset    = 1'b1;
        bus.init = 1'b0;
        bus.op_A = 32'd0;
        bus.op_B = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_q", bus.quotient, 32'd0);
        chk("reset_r", {16'd0, bus.remainder}, 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        chk("reset_dz", {31'd0, bus.dz}, 32'd0);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_op(32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 34);
        run_op(32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'd0, 1'b0, 34);
        run_op(32'd3, 16'd10, 32'd0, 16'd3, 1'b0, 34);
        run_op(32'd5, 16'd0, 32'hFFFF_FFFF, 16'h0005, 1'b1, 2);
        run_op(32'd9, 16'd3, 32'd3, 16'd0, 1'b0, 34);
        run_op(32'hFFFF_FFFF, 16'd1, 32'hFFFF_FFFF, 16'd0, 1'b0, 34);
        run_op(32'h1234_5678, 16'h0100, 32'h0012_3456, 16'h0078, 1'b0, 34);
        run_op(32'd0, 16'd1, 32'd0, 16'd0, 1'b0, 34);
        run_op(32'h0001_ABCD, 16'd0, 32'hFFFF_FFFF, 16'hABCD, 1'b1, 2);

        // Operand churn and stray init pulses while busy must not disturb the result.
        start_op(32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 34, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            bus.op_A = $urandom;
            bus.op_B = 16'($urandom);
            bus.init = (i % 3 == 0);
            @(negedge clk);
        end
        bus.init = 1'b0;
        wait_idle("churn", 200);

        // Asynchronous reset in the middle of the iteration phase.
        start_op(32'd100, 16'd7, 32'd0, 16'd0, 1'b0, 0, 1'b0);
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_done", {31'd0, bus.done}, 32'd0);
        chk("async_rst_q", bus.quotient, 32'd0);
        chk("async_rst_r", {16'd0, bus.remainder}, 32'd0);
        $display("reset asserted mid-division at cycle %0d", cyc);
        last_q = 32'd0;
        last_r = 16'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_op(32'd1000, 16'd33, 32'd30, 16'd10, 1'b0, 34);

        // init held high: back-to-back operations, one idle cycle apart.
        @(negedge clk);
        bus.op_A = 32'd50;
        bus.op_B = 16'd5;
        bus.init = 1'b1;
        s = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            push_exp(32'd10, 16'd0, 1'b0, s + k * (34 + HOLD + 1), 34);
        end
        $display("issue op_A=0x%08h op_B=0x%04h with init held", 32'd50, 16'd5);
        wait_idle("b2b", 400);
        bus.init = 1'b0;
        repeat (5) @(negedge clk);

        chk("done_rises", 32'(rises), 32'(pushed));
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("final_idle_done", {31'd0, bus.done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
